pipe_hazard_ctrl: RTL and testbench

//  Generates the per-stage STALL/CLEAR requests (*_STALL_D / *_CLEAR_D) consumed by the pipeline

---
 rtl/pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//   Produces the per-stage STALL/CLEAR requests for a nine-stage pipeline
//   (IF, ID1, ID2, EX1, EX2, ME1, ME2, WB1, WB2). The pipeline controller
//   forwards them unchanged to the stage registers. STALL holds a stage
//   register and CLEAR loads a bubble into it.
//
//   There are four hazard sources, listed from highest to lowest priority:
//   data-memory wait, multi-cycle EX op, branch redirect and load-use. The
//   block also keeps a saturating count of IF stall cycles and raises a
//   one-cycle error pulse when a multi-cycle op overruns its timeout.
//
// Parameters:
//   LU_CYCLES   total stall cycles per load-use hazard (1..15)
//   MC_TIMEOUT  max cycles spent in MC_WAIT before forced exit (2..65535)
//   CNT_W       width of STALL_CNT
//
// Ports:
//   CLK          in   clock, rising edge
//   RST          in   asynchronous active-high reset
//   DMEM_WAIT    in   data memory not ready for the ME2 access
//   MC_START     in   multi-cycle op enters EX2 this cycle
//   MC_DONE      in   multi-cycle op result valid
//   REDIRECT     in   EX2 branch mispredict; fetch PC is corrected this cycle
//   LD_USE_HZ    in   ID2 consumes the destination of a load in EX1/EX2
//   <S>_STALL_D  out  stall request for stage S (IF..WB2)
//   <S>_CLEAR_D  out  clear (bubble) request for stage S (ID1..WB2)
//   STALL_CNT    out  saturating count of cycles with IF_STALL_D=1
//   MC_ERR       out  one-cycle pulse after an MC_WAIT timeout
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned LU_CYCLES  = 2,
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DMEM_WAIT,
  input  logic             MC_START,
  input  logic             MC_DONE,
  input  logic             REDIRECT,
  input  logic             LD_USE_HZ,
  output logic             IF_STALL_D,
  output logic             ID1_STALL_D,
  output logic             ID1_CLEAR_D,
  output logic             ID2_STALL_D,
  output logic             ID2_CLEAR_D,
  output logic             EX1_STALL_D,
  output logic             EX1_CLEAR_D,
  output logic             EX2_STALL_D,
  output logic             EX2_CLEAR_D,
  output logic             ME1_STALL_D,
  output logic             ME1_CLEAR_D,
  output logic             ME2_STALL_D,
  output logic             ME2_CLEAR_D,
  output logic             WB1_STALL_D,
  output logic             WB1_CLEAR_D,
  output logic             WB2_STALL_D,
  output logic             WB2_CLEAR_D,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic             MC_ERR
);

  // Stage indices into the internal request vectors.
  localparam int S_IF  = 0;
  localparam int S_ID1 = 1;
  localparam int S_ID2 = 2;
  localparam int S_EX1 = 3;
  localparam int S_EX2 = 4;
  localparam int S_ME1 = 5;
  localparam int S_ME2 = 6;
  localparam int S_WB1 = 7;

  localparam logic [3:0]  LU_RELOAD = 4'(LU_CYCLES - 1);
  localparam logic [15:0] MC_LAST   = 16'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MC_WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         lu_cnt_q, lu_cnt_d;
  logic [15:0]        mc_cnt_q, mc_cnt_d;
  logic               redir_pend_q, redir_pend_d;
  logic               mc_err_q, mc_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  // WB2 is the last stage and is never stalled or cleared, so it has no
  // entry in these vectors.
  logic [S_WB1:S_IF]  stall_v;
  logic [S_WB1:S_ID1] clear_v;

  // ---------------------------------------------------------------------------
  // Next-state and request logic. The hazard rules are applied in priority
  // order, and only the first rule that matches has any effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets its default value before the first branch. A path
    // that leaves a signal unassigned would infer a latch.
    state_d      = state_q;
    lu_cnt_d     = lu_cnt_q;
    mc_cnt_d     = mc_cnt_q;
    redir_pend_d = redir_pend_q;
    mc_err_d     = 1'b0;
    stall_v      = '0;
    clear_v      = '0;

    if (DMEM_WAIT) begin
      // The whole front of the pipe waits on memory. FSM state and counters
      // are frozen and MC_DONE is ignored. A redirect is remembered until the
      // pipe can act on it.
      stall_v[S_ME2:S_IF] = '1;
      clear_v[S_WB1]      = 1'b1;
      if (REDIRECT) redir_pend_d = 1'b1;
    end else if (state_q == ST_MC_WAIT) begin
      stall_v[S_EX2:S_IF] = '1;
      clear_v[S_ME1]      = 1'b1;
      mc_cnt_d            = mc_cnt_q + 16'd1;
      if (MC_DONE) begin
        state_d = ST_RUN;
      end else if (mc_cnt_q == MC_LAST) begin
        state_d  = ST_RUN;
        mc_err_d = 1'b1;
      end
      if (REDIRECT) redir_pend_d = 1'b1;
    end else if (REDIRECT || redir_pend_q) begin
      // Squash the wrong-path instructions. Because the load-use consumer is
      // among them, any load-use stall in progress is abandoned.
      clear_v[S_EX1:S_ID1] = '1;
      redir_pend_d         = 1'b0;
      state_d              = ST_RUN;
    end else if (state_q == ST_RUN && MC_START) begin
      stall_v[S_EX2:S_IF] = '1;
      clear_v[S_ME1]      = 1'b1;
      mc_cnt_d            = '0;
      state_d             = ST_MC_WAIT;
    end else if (state_q == ST_RUN && LD_USE_HZ) begin
      // The first stall cycle is spent in RUN. LU_STALL covers the rest.
      stall_v[S_ID2:S_IF] = '1;
      clear_v[S_EX1]      = 1'b1;
      if (LU_CYCLES > 1) begin
        lu_cnt_d = LU_RELOAD;
        state_d  = ST_LU_STALL;
      end
    end else if (state_q == ST_LU_STALL) begin
      stall_v[S_ID2:S_IF] = '1;
      clear_v[S_EX1]      = 1'b1;
      lu_cnt_d            = lu_cnt_q - 4'd1;
      if (lu_cnt_q == 4'd1) state_d = ST_RUN;
    end

    if (stall_v[S_IF] && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    // Reset bubbles the whole pipe at once, without waiting for a clock edge.
    if (RST) begin
      stall_v = '0;
      clear_v = '1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_RUN;
      lu_cnt_q     <= '0;
      mc_cnt_q     <= '0;
      redir_pend_q <= 1'b0;
      mc_err_q     <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here. All registers then update
      // together from values that were stable before the edge.
      state_q      <= state_d;
      lu_cnt_q     <= lu_cnt_d;
      mc_cnt_q     <= mc_cnt_d;
      redir_pend_q <= redir_pend_d;
      mc_err_q     <= mc_err_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign IF_STALL_D  = stall_v[S_IF];
  assign ID1_STALL_D = stall_v[S_ID1];
  assign ID2_STALL_D = stall_v[S_ID2];
  assign EX1_STALL_D = stall_v[S_EX1];
  assign EX2_STALL_D = stall_v[S_EX2];
  assign ME1_STALL_D = stall_v[S_ME1];
  assign ME2_STALL_D = stall_v[S_ME2];
  assign WB1_STALL_D = stall_v[S_WB1];
  assign WB2_STALL_D = 1'b0;

  assign ID1_CLEAR_D = clear_v[S_ID1];
  assign ID2_CLEAR_D = clear_v[S_ID2];
  assign EX1_CLEAR_D = clear_v[S_EX1];
  assign EX2_CLEAR_D = clear_v[S_EX2];
  assign ME1_CLEAR_D = clear_v[S_ME1];
  assign ME2_CLEAR_D = clear_v[S_ME2];
  assign WB1_CLEAR_D = clear_v[S_WB1];
  // WB2_CLEAR_D stays low even in reset: WB2 is the last stage and is never
  // bubbled.
  assign WB2_CLEAR_D = 1'b0;

  assign STALL_CNT = stall_cnt_q;
  assign MC_ERR    = mc_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Two instances of pipe_hazard_ctrl share one set of inputs:
//   dut_a: LU_CYCLES=2, MC_TIMEOUT=8, CNT_W=5 (the narrow STALL_CNT saturates)
//   dut_b: LU_CYCLES=4, MC_TIMEOUT=8, CNT_W=32
// A behavioural model for each instance tracks "remaining load-use cycles",
// "age of the multi-cycle op" and a pending-redirect flag, and predicts every
// output cycle by cycle.
//
// Output vector layout (17 bits):
//   [16:8] STALL for IF,ID1,ID2,EX1,EX2,ME1,ME2,WB1,WB2
//   [7:0]  CLEAR for ID1,ID2,EX1,EX2,ME1,ME2,WB1,WB2
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO   = 8;
  localparam int unsigned LU_A = 2;
  localparam int unsigned LU_B = 4;
  localparam int unsigned CW_A = 5;
  localparam int unsigned CW_B = 32;

  logic CLK, RST, DMEM_WAIT, MC_START, MC_DONE, REDIRECT, LD_USE_HZ;
  logic [16:0]     out_a, out_b;
  logic [CW_A-1:0] cnt_a;
  logic [CW_B-1:0] cnt_b;
  logic            err_a, err_b;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic   in_mc;    // a multi-cycle op is occupying EX2
    int     mc_age;   // cycles already spent waiting on it
    int     lu_left;  // load-use stall cycles still owed after this one
    logic   pend;     // redirect seen while the pipe could not act on it
    logic   err;      // registered MC_ERR
    longint cnt;      // registered STALL_CNT
  } mdl_t;

  mdl_t mdl [2];

  pipe_hazard_ctrl #(.LU_CYCLES(LU_A), .MC_TIMEOUT(TO), .CNT_W(CW_A)) dut_a (
    .CLK(CLK), .RST(RST), .DMEM_WAIT(DMEM_WAIT), .MC_START(MC_START),
    .MC_DONE(MC_DONE), .REDIRECT(REDIRECT), .LD_USE_HZ(LD_USE_HZ),
    .IF_STALL_D(out_a[16]),
    .ID1_STALL_D(out_a[15]), .ID2_STALL_D(out_a[14]), .EX1_STALL_D(out_a[13]),
    .EX2_STALL_D(out_a[12]), .ME1_STALL_D(out_a[11]), .ME2_STALL_D(out_a[10]),
    .WB1_STALL_D(out_a[9]),  .WB2_STALL_D(out_a[8]),
    .ID1_CLEAR_D(out_a[7]),  .ID2_CLEAR_D(out_a[6]),  .EX1_CLEAR_D(out_a[5]),
    .EX2_CLEAR_D(out_a[4]),  .ME1_CLEAR_D(out_a[3]),  .ME2_CLEAR_D(out_a[2]),
    .WB1_CLEAR_D(out_a[1]),  .WB2_CLEAR_D(out_a[0]),
    .STALL_CNT(cnt_a), .MC_ERR(err_a)
  );

  pipe_hazard_ctrl #(.LU_CYCLES(LU_B), .MC_TIMEOUT(TO), .CNT_W(CW_B)) dut_b (
    .CLK(CLK), .RST(RST), .DMEM_WAIT(DMEM_WAIT), .MC_START(MC_START),
    .MC_DONE(MC_DONE), .REDIRECT(REDIRECT), .LD_USE_HZ(LD_USE_HZ),
    .IF_STALL_D(out_b[16]),
    .ID1_STALL_D(out_b[15]), .ID2_STALL_D(out_b[14]), .EX1_STALL_D(out_b[13]),
    .EX2_STALL_D(out_b[12]), .ME1_STALL_D(out_b[11]), .ME2_STALL_D(out_b[10]),
    .WB1_STALL_D(out_b[9]),  .WB2_STALL_D(out_b[8]),
    .ID1_CLEAR_D(out_b[7]),  .ID2_CLEAR_D(out_b[6]),  .EX1_CLEAR_D(out_b[5]),
    .EX2_CLEAR_D(out_b[4]),  .ME1_CLEAR_D(out_b[3]),  .ME2_CLEAR_D(out_b[2]),
    .WB1_CLEAR_D(out_b[1]),  .WB2_CLEAR_D(out_b[0]),
    .STALL_CNT(cnt_b), .MC_ERR(err_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies one cycle of the hazard rules to model `id`. It returns the
  // expected request vector and updates the model's registered state.
  task automatic model_step(input int id, output logic [16:0] ev);
    int         lu;
    int         depth;     // number of stages stalled, counting from IF
    logic [8:1] clr;       // clear per stage, ID1=1 .. WB2=8
    logic       nerr;
    longint     cmax;
    lu    = (id == 0) ? int'(LU_A) : int'(LU_B);
    cmax  = (id == 0) ? ((longint'(1) << CW_A) - 1) : ((longint'(1) << CW_B) - 1);
    depth = 0;
    clr   = '0;
    nerr  = 1'b0;
    if (DMEM_WAIT) begin
      depth  = 7;
      clr[7] = 1'b1;
      if (REDIRECT) mdl[id].pend = 1'b1;
    end else if (mdl[id].in_mc) begin
      depth  = 5;
      clr[5] = 1'b1;
      mdl[id].mc_age++;
      if (MC_DONE) begin
        mdl[id].in_mc = 1'b0;
      end else if (mdl[id].mc_age == int'(TO)) begin
        mdl[id].in_mc = 1'b0;
        nerr          = 1'b1;
      end
      if (REDIRECT) mdl[id].pend = 1'b1;
    end else if (REDIRECT || mdl[id].pend) begin
      clr[1] = 1'b1;
      clr[2] = 1'b1;
      clr[3] = 1'b1;
      mdl[id].pend    = 1'b0;
      mdl[id].lu_left = 0;
    end else if (mdl[id].lu_left > 0) begin
      depth  = 3;
      clr[3] = 1'b1;
      mdl[id].lu_left--;
    end else if (MC_START) begin
      depth  = 5;
      clr[5] = 1'b1;
      mdl[id].in_mc  = 1'b1;
      mdl[id].mc_age = 0;
    end else if (LD_USE_HZ) begin
      depth  = 3;
      clr[3] = 1'b1;
      mdl[id].lu_left = lu - 1;
    end
    for (int k = 0; k < 9; k++) ev[16-k] = (k < depth);
    for (int k = 1; k <= 8; k++) ev[8-k] = clr[k];
    if (depth > 0 && mdl[id].cnt < cmax) mdl[id].cnt++;
    mdl[id].err = nerr;
  endtask

  // Called just after a rising edge. It drives the inputs for one cycle and
  // checks both instances on the falling edge.
  task automatic step(input logic dmem, input logic mcs, input logic mcd,
                      input logic redir, input logic luh);
    logic [16:0] ev;
    DMEM_WAIT = dmem;
    MC_START  = mcs;
    MC_DONE   = mcd;
    REDIRECT  = redir;
    LD_USE_HZ = luh;
    @(negedge CLK);
    check("a_cnt", 64'(cnt_a), mdl[0].cnt);
    check("a_err", 64'(err_a), 64'(mdl[0].err));
    model_step(0, ev);
    check("a_out", 64'(out_a), 64'(ev));
    check("b_cnt", 64'(cnt_b), mdl[1].cnt);
    check("b_err", 64'(err_b), 64'(mdl[1].err));
    model_step(1, ev);
    check("b_out", 64'(out_b), 64'(ev));
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset at the current time, even in the middle of a cycle. The
  // other inputs are randomised to show that they have no effect.
  task automatic do_reset();
    RST       = 1'b1;
    DMEM_WAIT = 1'($urandom_range(0, 1));
    MC_START  = 1'($urandom_range(0, 1));
    MC_DONE   = 1'($urandom_range(0, 1));
    REDIRECT  = 1'($urandom_range(0, 1));
    LD_USE_HZ = 1'($urandom_range(0, 1));
    #1;
    // WB2_CLEAR_D (bit 0) is left out of the reset comparison.
    check("a_rst_out", 64'(out_a[16:1]), 64'({9'b0, 7'h7f}));
    check("b_rst_out", 64'(out_b[16:1]), 64'({9'b0, 7'h7f}));
    check("a_rst_cnt", 64'(cnt_a), 64'd0);
    check("b_rst_cnt", 64'(cnt_b), 64'd0);
    check("a_rst_err", 64'(err_a), 64'd0);
    check("b_rst_err", 64'(err_b), 64'd0);
    mdl[0] = '0;
    mdl[1] = '0;
    @(negedge CLK);
    RST       = 1'b0;
    DMEM_WAIT = 1'b0;
    MC_START  = 1'b0;
    MC_DONE   = 1'b0;
    REDIRECT  = 1'b0;
    LD_USE_HZ = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic pick(input int unsigned pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  initial begin
    RST       = 1'b1;
    DMEM_WAIT = 1'b0;
    MC_START  = 1'b0;
    MC_DONE   = 1'b0;
    REDIRECT  = 1'b0;
    LD_USE_HZ = 1'b0;
    @(posedge CLK);
    #1;
    do_reset();
    idle(2);

    // Single-cycle load-use hazard.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    check("t1_cnt_a", 64'(cnt_a), 64'd2);
    check("t1_cnt_b", 64'(cnt_b), 64'd4);

    // Multi-cycle op completing five cycles after it starts.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("t2_cnt_a", 64'(cnt_a), 64'd6);
    check("t2_cnt_b", 64'(cnt_b), 64'd6);

    // Multi-cycle op that never signals completion and times out.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(12);
    check("t3_cnt_a", 64'(cnt_a), 64'd9);
    check("t3_cnt_b", 64'(cnt_b), 64'd9);

    // Memory wait with a redirect that stays pending until the wait ends.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("t4_cnt_a", 64'(cnt_a), 64'd3);
    check("t4_cnt_b", 64'(cnt_b), 64'd3);

    // Redirect that arrives during the load-use stall.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    check("t5_cnt_a", 64'(cnt_a), 64'd2);
    check("t5_cnt_b", 64'(cnt_b), 64'd2);

    // Reset asserted in the middle of a cycle while in MC_WAIT.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    #2;
    do_reset();
    idle(3);
    check("t6_cnt_b", 64'(cnt_b), 64'd0);

    // The 5-bit counter saturates at all-ones, while the wide one keeps counting.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("sat_cnt_a", 64'(cnt_a), 64'd31);
    check("sat_cnt_b", 64'(cnt_b), 64'd40);

    // Random traffic, with an occasional reset.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      step(pick(15), pick(10), pick(15), pick(10), pick(25));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
